mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage in the RV32I core.
- Takes the registered instruction, destination register index, ALU result (the effective address for loads and stores) and store data from the execute stage.
- Performs data-memory loads and stores over a req/gnt/rvalid handshake and stalls upstream while a memory access is in flight.
- Sends write-back data, destination index and write enable to the write-back stage.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/load_align.sv | 25 ++
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the memory stage and its load aligner.
package riscv_pkg;

  // Major opcodes the memory stage needs to recognise
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a load word down to bit 0 and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_size_e   size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the selected lane to the bottom, then sign- or zero-extend by size
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    result  = shifted;
    case (size)
      BYTE:    result = {{24{sign & shifted[7]}}, shifted[7:0]};
      HALF:    result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores over req/gnt/rvalid and feeds write-back.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [4:0]        sel_rd_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       rs2_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [4:0]        sel_rd_o,
  output logic [31:0]       rd_wdata_o,
  output logic              rd_we_o,
  output logic              mem_err_o
);

  mem_state_e        state, next_state;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load, is_store, is_mem, legal_f3, misaligned, mem_ok;
  mem_size_e         size_d;
  logic              sign_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;

  logic [31:0]       instr_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  mem_size_e         size_q;
  logic              sign_q;
  logic              store_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_data;

  // Decode the incoming instruction: access size, legality, alignment, lanes
  always_comb begin
    opcode   = instr_i[6:0];
    funct3   = instr_i[14:12];
    is_load  = (opcode == LOAD);
    is_store = (opcode == STORE);
    is_mem   = is_load | is_store;
    size_d   = BYTE;
    sign_d   = 1'b0;
    case (funct3)
      F3_LB:   begin size_d = BYTE; sign_d = 1'b1; end
      F3_LH:   begin size_d = HALF; sign_d = 1'b1; end
      F3_LW:   size_d = WORD;
      F3_LBU:  size_d = BYTE;
      F3_LHU:  size_d = HALF;
      default: size_d = BYTE;
    endcase
    if (is_load) begin
      legal_f3 = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end else begin
      legal_f3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end
    misaligned = ((size_d == HALF) && alu_result_i[0]) ||
                 ((size_d == WORD) && (alu_result_i[1:0] != 2'b00));
    mem_ok     = is_mem && legal_f3 && !misaligned;
    case (size_d)
      BYTE: begin
        be_d    = 4'b0001 << alu_result_i[1:0];
        wdata_d = {4{rs2_i[7:0]}};
      end
      HALF: begin
        be_d    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{rs2_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = rs2_i;
      end
    endcase
  end

  // State register; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: accept legal accesses, wait for grant, then for load data
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_i && mem_ok) next_state = REQ;
      REQ:     if (dmem_gnt_i) next_state = store_q ? IDLE : WAIT_R;
      WAIT_R:  if (dmem_rvalid_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the access at acceptance so the request stays stable until grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      size_q  <= BYTE;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && valid_i && mem_ok) begin
      instr_q <= instr_i;
      rd_q    <= sel_rd_i;
      addr_q  <= alu_result_i[ADDR_W-1:0];
      size_q  <= size_d;
      sign_q  <= sign_d;
      store_q <= is_store;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .addr   (addr_q[1:0]),
    .size   (size_q),
    .sign   (sign_q),
    .result (load_data)
  );

  // Registered write-back outputs; valid_o is a single-cycle retire pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      instr_o    <= '0;
      sel_rd_o   <= '0;
      rd_wdata_o <= '0;
      rd_we_o    <= 1'b0;
      mem_err_o  <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      rd_we_o   <= 1'b0;
      mem_err_o <= 1'b0;
      case (state)
        IDLE: if (valid_i && !mem_ok) begin
          valid_o    <= 1'b1;
          instr_o    <= instr_i;
          sel_rd_o   <= sel_rd_i;
          rd_wdata_o <= alu_result_i;
          mem_err_o  <= is_mem;
          rd_we_o    <= !is_mem && (opcode != BRANCH) && (sel_rd_i != 5'd0);
        end
        REQ: if (dmem_gnt_i && store_q) begin
          valid_o  <= 1'b1;
          instr_o  <= instr_q;
          sel_rd_o <= rd_q;
        end
        WAIT_R: if (dmem_rvalid_i) begin
          valid_o    <= 1'b1;
          instr_o    <= instr_q;
          sel_rd_o   <= rd_q;
          rd_wdata_o <= load_data;
          rd_we_o    <= (rd_q != 5'd0);
        end
        default: ;
      endcase
    end
  end

  assign stall_o      = (state != IDLE);
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = store_q;
  assign dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, random ops vs. byte memory model, resets.
module tb_mem_stage;

  localparam int K_IMM   = 0;
  localparam int K_STORE = 1;
  localparam int K_LOAD  = 2;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    int          kind;
    logic [31:0] wb;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  logic        clk, rst_n;
  logic        valid_i;
  logic [31:0] instr_i, alu_result_i, rs2_i;
  logic [4:0]  sel_rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o, rd_we_o, mem_err_o;
  logic [31:0] instr_o, rd_wdata_o;
  logic [4:0]  sel_rd_o;

  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] mem_model [0:63];
  vec_t table_q [$];

  mem_stage #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .instr_i       (instr_i),
    .sel_rd_i      (sel_rd_i),
    .alu_result_i  (alu_result_i),
    .rs2_i         (rs2_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .sel_rd_o      (sel_rd_o),
    .rd_wdata_o    (rd_wdata_o),
    .rd_we_o       (rd_we_o),
    .mem_err_o     (mem_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input int gd, input int rvd, input logic [31:0] rdata,
                              input int kind, input logic [31:0] wb, input logic we,
                              input logic err, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
    vec_t v;
    v.instr = instr; v.rd = rd; v.alu = alu; v.rs2 = rs2;
    v.gd = gd; v.rvd = rvd; v.rdata = rdata;
    v.kind = kind; v.wb = wb; v.we = we; v.err = err;
    v.addr = addr; v.be = be; v.wdata = wdata;
    return v;
  endfunction

  // Reference model: byte-addressed memory, RV32I load/store rules in plain arithmetic
  function automatic vec_t predict(input logic [31:0] instr, input logic [4:0] rd,
                                   input logic [31:0] alu, input logic [31:0] rs2);
    vec_t v;
    int f3, nb, off, base;
    logic legal, is_ld;
    logic [31:0] val;
    v = mk(instr, rd, alu, rs2, 0, 0, 32'h0, K_IMM, alu, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    is_ld = (instr[6:0] == 7'h03);
    if (instr[6:0] != 7'h03 && instr[6:0] != 7'h23) begin
      v.we = (instr[6:0] != 7'h63) && (rd != 5'd0);
      return v;
    end
    f3 = int'(instr[14:12]);
    nb = 1 << (f3 % 4);
    legal = is_ld ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
    if (!legal || (int'(alu) % nb) != 0) begin
      v.err = 1'b1;
      return v;
    end
    off    = int'(alu) % 4;
    base   = int'(alu) - off;
    v.addr = alu - 32'(off);
    v.be   = 4'(((1 << nb) - 1) << off);
    if (is_ld) begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(mem_model[int'(alu) + i]) << (8 * i));
      if (f3 < 4 && nb < 4 && val[8 * nb - 1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
      v.rdata = {mem_model[base + 3], mem_model[base + 2], mem_model[base + 1], mem_model[base]};
      v.kind  = K_LOAD;
      v.wb    = val;
      v.we    = (rd != 5'd0);
    end else begin
      v.kind = K_STORE;
      if (nb == 1)      v.wdata = (rs2 & 32'hFF) * 32'h01010101;
      else if (nb == 2) v.wdata = (rs2 & 32'hFFFF) * 32'h00010001;
      else              v.wdata = rs2;
      for (int i = 0; i < nb; i++) mem_model[int'(alu) + i] = 8'(rs2 >> (8 * i));
    end
    return v;
  endfunction

  // Present one instruction, play the memory side, and check the retire pulse
  task automatic applyStimulus(input vec_t v);
    checkOutput("stall_before_issue", 32'(stall_o), 32'd0);
    valid_i = 1'b1; instr_i = v.instr; sel_rd_i = v.rd; alu_result_i = v.alu; rs2_i = v.rs2;
    nextCycle();
    valid_i = 1'b0; instr_i = $urandom; sel_rd_i = 5'($urandom);
    alu_result_i = $urandom; rs2_i = $urandom;
    if (v.kind == K_IMM) begin
      checkOutput("imm_valid", 32'(valid_o), 32'd1);
      checkOutput("imm_err", 32'(mem_err_o), 32'(v.err));
      checkOutput("imm_we", 32'(rd_we_o), 32'(v.we));
      checkOutput("imm_instr", instr_o, v.instr);
      checkOutput("imm_rd", 32'(sel_rd_o), 32'(v.rd));
      if (!v.err) checkOutput("imm_wdata", rd_wdata_o, v.wb);
      checkOutput("imm_stall", 32'(stall_o), 32'd0);
      checkOutput("imm_noreq", 32'(dmem_req_o), 32'd0);
    end else begin
      for (int c = 0; c <= v.gd; c++) begin
        checkOutput("req_stall", 32'(stall_o), 32'd1);
        checkOutput("req_valid", 32'(valid_o), 32'd0);
        checkOutput("req_req", 32'(dmem_req_o), 32'd1);
        checkOutput("req_we", 32'(dmem_we_o), 32'(v.kind == K_STORE));
        checkOutput("req_addr", dmem_addr_o, v.addr);
        checkOutput("req_be", 32'(dmem_be_o), 32'(v.be));
        if (v.kind == K_STORE) checkOutput("req_wdata", dmem_wdata_o, v.wdata);
        dmem_gnt_i    = (c == v.gd);
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i  = $urandom;
        nextCycle();
      end
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (v.kind == K_STORE) begin
        checkOutput("st_valid", 32'(valid_o), 32'd1);
        checkOutput("st_we", 32'(rd_we_o), 32'd0);
        checkOutput("st_err", 32'(mem_err_o), 32'd0);
        checkOutput("st_instr", instr_o, v.instr);
        checkOutput("st_stall", 32'(stall_o), 32'd0);
      end else begin
        checkOutput("wait_noreq", 32'(dmem_req_o), 32'd0);
        for (int c = 0; c <= v.rvd; c++) begin
          checkOutput("wait_stall", 32'(stall_o), 32'd1);
          checkOutput("wait_valid", 32'(valid_o), 32'd0);
          dmem_rvalid_i = (c == v.rvd);
          dmem_rdata_i  = (c == v.rvd) ? v.rdata : $urandom;
          nextCycle();
        end
        dmem_rvalid_i = 1'b0;
        checkOutput("ld_valid", 32'(valid_o), 32'd1);
        checkOutput("ld_data", rd_wdata_o, v.wb);
        checkOutput("ld_we", 32'(rd_we_o), 32'(v.we));
        checkOutput("ld_err", 32'(mem_err_o), 32'd0);
        checkOutput("ld_instr", instr_o, v.instr);
        checkOutput("ld_rd", 32'(sel_rd_o), 32'(v.rd));
        checkOutput("ld_stall", 32'(stall_o), 32'd0);
      end
    end
    nextCycle();
    checkOutput("pulse_end", 32'(valid_o), 32'd0);
  endtask

  // Checks that every output sits at its reset value
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, "_req"}, 32'(dmem_req_o), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_rdwe"}, 32'(rd_we_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(mem_err_o), 32'd0);
    checkOutput({tag, "_wbdata"}, rd_wdata_o, 32'd0);
    checkOutput({tag, "_addr"}, dmem_addr_o, 32'd0);
  endtask

  initial begin
    logic [6:0] alu_ops [6];
    logic [31:0] instr;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] alu;
    vec_t v;

    rst_n = 1'b0; valid_i = 1'b0; instr_i = '0; sel_rd_i = '0; alu_result_i = '0;
    rs2_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = 8'($urandom);
    repeat (3) nextCycle();
    checkResetState("reset");
    rst_n = 1'b1;
    nextCycle();

    // Directed vectors with hand-derived expectations
    table_q.push_back(mk(32'h000002B3, 5'd5, 32'h1234, 32'h0, 0, 0, 32'h0, K_IMM, 32'h1234, 1, 0, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00000383, 5'd7, 32'h1003, 32'h0, 0, 1, 32'h80000000, K_LOAD, 32'hFFFFFF80, 1, 0, 32'h1000, 4'b1000, 0));
    table_q.push_back(mk(32'h00004383, 5'd7, 32'h1003, 32'h0, 0, 0, 32'h80000000, K_LOAD, 32'h00000080, 1, 0, 32'h1000, 4'b1000, 0));
    table_q.push_back(mk(32'h00001023, 5'd0, 32'h2002, 32'hABCD1234, 0, 0, 32'h0, K_STORE, 32'h0, 0, 0, 32'h2000, 4'b1100, 32'h12341234));
    table_q.push_back(mk(32'h00002283, 5'd5, 32'h0001, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0, 0, 1, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00002003, 5'd0, 32'h0040, 32'h0, 3, 2, 32'hDEADBEEF, K_LOAD, 32'hDEADBEEF, 0, 0, 32'h0040, 4'b1111, 0));
    table_q.push_back(mk(32'h00000063, 5'd3, 32'h0055, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0055, 0, 0, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00000013, 5'd0, 32'h0077, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0077, 0, 0, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00003003, 5'd4, 32'h0010, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0, 0, 1, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00004023, 5'd0, 32'h0010, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0, 0, 1, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00001483, 5'd9, 32'h0102, 32'h0, 1, 0, 32'h80010000, K_LOAD, 32'hFFFF8001, 1, 0, 32'h0100, 4'b1100, 0));
    table_q.push_back(mk(32'h00005483, 5'd9, 32'h0102, 32'h0, 0, 3, 32'h80010000, K_LOAD, 32'h00008001, 1, 0, 32'h0100, 4'b1100, 0));
    table_q.push_back(mk(32'h00000023, 5'd0, 32'h0005, 32'h000000A5, 2, 0, 32'h0, K_STORE, 32'h0, 0, 0, 32'h0004, 4'b0010, 32'hA5A5A5A5));
    table_q.push_back(mk(32'h00002023, 5'd0, 32'h0008, 32'h01234567, 0, 0, 32'h0, K_STORE, 32'h0, 0, 0, 32'h0008, 4'b1111, 32'h01234567));
    table_q.push_back(mk(32'h00001023, 5'd0, 32'h0021, 32'h0, 0, 0, 32'h0, K_IMM, 32'h0, 0, 1, 0, 4'h0, 0));
    table_q.push_back(mk(32'h00005083, 5'd1, 32'h0000, 32'h0, 0, 0, 32'h1234FFFF, K_LOAD, 32'h0000FFFF, 1, 0, 32'h0000, 4'b0011, 0));
    table_q.push_back(mk(32'h00000103, 5'd2, 32'h1001, 32'h0, 1, 1, 32'h00007F00, K_LOAD, 32'h0000007F, 1, 0, 32'h1000, 4'b0010, 0));
    foreach (table_q[i]) applyStimulus(table_q[i]);

    // Randomised instructions against the byte-memory model
    alu_ops[0] = 7'h33; alu_ops[1] = 7'h13; alu_ops[2] = 7'h37;
    alu_ops[3] = 7'h17; alu_ops[4] = 7'h6F; alu_ops[5] = 7'h63;
    for (int n = 0; n < 150; n++) begin
      instr = $urandom;
      f3    = 3'($urandom_range(0, 7));
      rd    = 5'($urandom);
      case ($urandom_range(0, 2))
        0: begin instr[6:0] = alu_ops[$urandom_range(0, 5)]; alu = $urandom; end
        1: begin instr[6:0] = 7'h03; alu = 32'($urandom_range(0, 63)); end
        default: begin instr[6:0] = 7'h23; alu = 32'($urandom_range(0, 63)); end
      endcase
      instr[14:12] = f3;
      v     = predict(instr, rd, alu, $urandom);
      v.gd  = $urandom_range(0, 3);
      v.rvd = $urandom_range(0, 3);
      applyStimulus(v);
    end

    // Reset while waiting for load data; the late rvalid must be ignored
    valid_i = 1'b1; instr_i = 32'h00002283; sel_rd_i = 5'd5; alu_result_i = 32'h10; rs2_i = 0;
    nextCycle();
    valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    nextCycle();
    dmem_gnt_i = 1'b0;
    checkOutput("rst_wait_stall", 32'(stall_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetState("rst_wait");
    nextCycle();
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    nextCycle();
    dmem_rvalid_i = 1'b0;
    checkOutput("rst_late_rvalid_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_late_rvalid_stall", 32'(stall_o), 32'd0);
    nextCycle();
    checkOutput("rst_late_rvalid_valid2", 32'(valid_o), 32'd0);

    // Reset while requesting; the request must drop without a clock edge
    valid_i = 1'b1; instr_i = 32'h00002023; sel_rd_i = 5'd0; alu_result_i = 32'h20; rs2_i = 32'h55AA55AA;
    nextCycle();
    valid_i = 1'b0;
    checkOutput("rst_req_before", 32'(dmem_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetState("rst_req");
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("rst_req_after_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_req_after_req", 32'(dmem_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
